// File: rtl/inst_loader_if.sv
// Field-bundle handshake and instruction-memory write bus of the RV32I loader.
// The master drives decoded fields and control; the slave encodes and writes.
interface inst_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        cls;
    logic [3:0]        alu_op;
    logic [2:0]        f3;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              full;
    logic              err;
    logic [ADDR_W:0]   err_idx;

    modport master (
        output start, finish, in_valid, cls, alu_op, f3, rd, rs1, rs2, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, busy, full, err, err_idx
    );

    modport slave (
        input  start, finish, in_valid, cls, alu_op, f3, rd, rs1, rs2, imm,
        output in_ready, mem_we, mem_addr, mem_wdata, count, busy, full, err, err_idx
    );
endinterface

// File: rtl/inst_loader_encoder.sv
// Encodes RV32I instruction words from decoded fields, range-checks immediates
// and writes the words sequentially into instruction memory.
module inst_loader_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_loader_if.slave bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = '1;

    localparam logic [3:0] CLS_OP     = 4'd0;
    localparam logic [3:0] CLS_OPIMM  = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_LUI    = 4'd7;
    localparam logic [3:0] CLS_AUIPC  = 4'd8;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_FULL,
        S_ERROR
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  err_idx_q, err_idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              in_ready_q, mem_we_q, busy_q;

    logic [2:0]  op_f3;
    logic [6:0]  op_f7;
    logic        op_ok;
    logic        op_shift;
    logic        imm_i_ok, imm_b_ok, imm_j_ok, imm_u_ok, shamt_ok;
    logic        load_f3_ok;
    logic        enc_ok_c;
    logic [31:0] enc_word_c;

    // ALU code to funct3/funct7, shared by OP and OP-IMM
    always_comb begin : alu_map
        op_f3    = 3'b000;
        op_f7    = 7'b0000000;
        op_ok    = 1'b1;
        op_shift = 1'b0;
        case (bus.alu_op)
            4'd1:  op_f3 = 3'b000;
            4'd2:  op_f7 = F7_ALT;
            4'd3:  begin op_f3 = 3'b001; op_shift = 1'b1; end
            4'd4:  op_f3 = 3'b010;
            4'd5:  op_f3 = 3'b011;
            4'd6:  op_f3 = 3'b100;
            4'd7:  begin op_f3 = 3'b101; op_shift = 1'b1; end
            4'd8:  begin op_f3 = 3'b101; op_f7 = F7_ALT; op_shift = 1'b1; end
            4'd9:  op_f3 = 3'b110;
            4'd10: op_f3 = 3'b111;
            default: op_ok = 1'b0;
        endcase
    end

    // A value fits in N signed bits when every bit above N-2 matches the sign
    assign imm_i_ok = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
    assign imm_b_ok = ((&bus.imm[31:12]) | ~(|bus.imm[31:12])) & ~bus.imm[0];
    assign imm_j_ok = ((&bus.imm[31:20]) | ~(|bus.imm[31:20])) & ~bus.imm[0];
    assign imm_u_ok = ~(|bus.imm[11:0]);
    assign shamt_ok = ~(|bus.imm[31:5]);

    always_comb begin : load_width
        load_f3_ok = 1'b0;
        case (bus.f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_f3_ok = 1'b1;
            default: load_f3_ok = 1'b0;
        endcase
    end

    // Field bundle to instruction word plus legality
    always_comb begin : encode
        enc_ok_c   = 1'b0;
        enc_word_c = 32'h0;
        case (bus.cls)
            CLS_OP: begin
                enc_ok_c   = op_ok;
                enc_word_c = {op_f7, bus.rs2, bus.rs1, op_f3, bus.rd, OPC_OP};
            end
            CLS_OPIMM: begin
                if (op_shift) begin
                    enc_ok_c   = op_ok & shamt_ok;
                    enc_word_c = {op_f7, bus.imm[4:0], bus.rs1, op_f3, bus.rd, OPC_OPIMM};
                end else begin
                    enc_ok_c   = op_ok & imm_i_ok & (bus.alu_op != ALU_SUB);
                    enc_word_c = {bus.imm[11:0], bus.rs1, op_f3, bus.rd, OPC_OPIMM};
                end
            end
            CLS_LOAD: begin
                enc_ok_c   = imm_i_ok & load_f3_ok;
                enc_word_c = {bus.imm[11:0], bus.rs1, bus.f3, bus.rd, OPC_LOAD};
            end
            CLS_STORE: begin
                enc_ok_c   = imm_i_ok & (bus.f3 <= 3'b010);
                enc_word_c = {bus.imm[11:5], bus.rs2, bus.rs1, bus.f3, bus.imm[4:0], OPC_STORE};
            end
            CLS_BRANCH: begin
                enc_ok_c   = imm_b_ok & (bus.f3 != 3'b010) & (bus.f3 != 3'b011);
                enc_word_c = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.f3,
                              bus.imm[4:1], bus.imm[11], OPC_BRANCH};
            end
            CLS_JAL: begin
                enc_ok_c   = imm_j_ok;
                enc_word_c = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                              bus.rd, OPC_JAL};
            end
            CLS_JALR: begin
                enc_ok_c   = imm_i_ok;
                enc_word_c = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, OPC_JALR};
            end
            CLS_LUI: begin
                enc_ok_c   = imm_u_ok;
                enc_word_c = {bus.imm[31:12], bus.rd, OPC_LUI};
            end
            CLS_AUIPC: begin
                enc_ok_c   = imm_u_ok;
                enc_word_c = {bus.imm[31:12], bus.rd, OPC_AUIPC};
            end
            default: begin
                enc_ok_c   = 1'b0;
                enc_word_c = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next datapath values; start overrides everything
    always_comb begin : next_state
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        err_idx_d = err_idx_q;
        wdata_d   = wdata_q;
        full_d    = full_q;
        err_d     = err_q;
        if (bus.start) begin
            state_d = S_ACCEPT;
            addr_d  = BASE;
            count_d = '0;
            err_d   = 1'b0;
            full_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_ACCEPT: begin
                    if (bus.in_valid) begin
                        if (enc_ok_c) begin
                            wdata_d = enc_word_c;
                            state_d = S_WRITE;
                        end else begin
                            err_d     = 1'b1;
                            err_idx_d = count_q;
                            state_d   = S_ERROR;
                        end
                    end else if (bus.finish) begin
                        state_d = S_IDLE;
                    end
                end
                S_WRITE: begin
                    count_d = count_q + CNT_W'(1);
                    if (addr_q == LAST) begin
                        full_d  = 1'b1;
                        state_d = S_FULL;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_ACCEPT;
                    end
                end
                S_FULL:  state_d = S_FULL;
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin : out_regs
        if (!rst_n) begin
            addr_q     <= BASE;
            count_q    <= '0;
            err_idx_q  <= '0;
            wdata_q    <= 32'h0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_idx_q  <= err_idx_d;
            wdata_q    <= wdata_d;
            full_q     <= full_d;
            err_q      <= err_d;
            in_ready_q <= (state_d == S_ACCEPT);
            mem_we_q   <= (state_d == S_WRITE);
            busy_q     <= (state_d == S_ACCEPT) || (state_d == S_WRITE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = count_q;
    assign bus.busy      = busy_q;
    assign bus.full      = full_q;
    assign bus.err       = err_q;
    assign bus.err_idx   = err_idx_q;
endmodule

// File: tb/tb_inst_loader_encoder.sv
// Randomized self-checking bench for inst_loader_encoder against a field-level
// RV32I encoding model; a small-address instance covers the full condition.
module tb_inst_loader_encoder;
    localparam int unsigned AW_BIG   = 10;
    localparam int unsigned AW_SMALL = 2;

    typedef struct {
        int cls;
        int alu;
        int f3;
        int rd;
        int rs1;
        int rs2;
        int imm;
    } bundle_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        start = 1'b0, finish = 1'b0, in_valid = 1'b0;
    logic [3:0]  cls = '0, alu_op = '0;
    logic [2:0]  f3 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;

    inst_loader_if #(.ADDR_W(AW_BIG))   bus_a ();
    inst_loader_if #(.ADDR_W(AW_SMALL)) bus_b ();

    inst_loader_encoder #(.ADDR_W(AW_BIG), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    inst_loader_encoder #(.ADDR_W(AW_SMALL), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    assign bus_a.start    = start & ~sel;
    assign bus_a.finish   = finish & ~sel;
    assign bus_a.in_valid = in_valid & ~sel;
    assign bus_b.start    = start & sel;
    assign bus_b.finish   = finish & sel;
    assign bus_b.in_valid = in_valid & sel;
    assign bus_a.cls = cls;       assign bus_b.cls = cls;
    assign bus_a.alu_op = alu_op; assign bus_b.alu_op = alu_op;
    assign bus_a.f3 = f3;         assign bus_b.f3 = f3;
    assign bus_a.rd = rd;         assign bus_b.rd = rd;
    assign bus_a.rs1 = rs1;       assign bus_b.rs1 = rs1;
    assign bus_a.rs2 = rs2;       assign bus_b.rs2 = rs2;
    assign bus_a.imm = imm;       assign bus_b.imm = imm;

    logic        o_ready, o_we, o_busy, o_full, o_err;
    logic [31:0] o_addr, o_data, o_count, o_eidx;
    assign o_ready = sel ? bus_b.in_ready : bus_a.in_ready;
    assign o_we    = sel ? bus_b.mem_we   : bus_a.mem_we;
    assign o_busy  = sel ? bus_b.busy     : bus_a.busy;
    assign o_full  = sel ? bus_b.full     : bus_a.full;
    assign o_err   = sel ? bus_b.err      : bus_a.err;
    assign o_addr  = sel ? 32'(bus_b.mem_addr) : 32'(bus_a.mem_addr);
    assign o_data  = sel ? bus_b.mem_wdata     : bus_a.mem_wdata;
    assign o_count = sel ? 32'(bus_b.count)    : 32'(bus_a.count);
    assign o_eidx  = sel ? 32'(bus_b.err_idx)  : 32'(bus_a.err_idx);

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the loader should look like after each transaction
    int m_aw = AW_BIG;
    int m_count = 0;
    int m_eidx = 0;
    bit m_open = 1'b0, m_full = 1'b0, m_err = 1'b0;
    int exp_writes = 0;
    int last_wait = 0;
    logic [31:0] last_word = '0;

    int bnd[16] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, 4095,
                    -4098, 1048574, -1048576, 1048576, 32'h7FFFF000, 32, 31, 32'h1000};

    int mon_writes = 0;
    int mon_b2b = 0;
    logic we_prev = 1'b0;
    always @(negedge clk) begin
        if (o_we) mon_writes <= mon_writes + 1;
        if (o_we && we_prev) mon_b2b <= mon_b2b + 1;
        we_prev <= o_we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit fits(input int s, input int n);
        return (s >= -(1 <<< (n - 1))) && (s < (1 <<< (n - 1)));
    endfunction

    // Encoding rules of RV32I written directly from the field layouts
    function automatic void ref_enc(input bundle_t b, output bit ok, output logic [31:0] w);
        int opc_tab[9] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h6F, 'h67, 'h37, 'h17};
        int alu_f3[11] = '{0, 0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        int s = b.imm;
        int opc, f3v, f7v, rdf, rs1f, rs2f, x;
        bit alu_ok, shift;
        ok = 1'b0;
        w  = '0;
        if (b.cls > 8) return;
        opc    = opc_tab[b.cls];
        alu_ok = (b.alu >= 1) && (b.alu <= 10);
        f3v    = alu_ok ? alu_f3[b.alu] : 0;
        f7v    = (b.alu == 2 || b.alu == 8) ? 32 : 0;
        shift  = (b.alu == 3 || b.alu == 7 || b.alu == 8);
        rdf    = b.rd << 7;
        rs1f   = b.rs1 << 15;
        rs2f   = b.rs2 << 20;
        x      = 0;
        case (b.cls)
            0: begin
                ok = alu_ok;
                x  = (f7v << 25) | rs2f | rs1f | (f3v << 12) | rdf | opc;
            end
            1: begin
                if (shift) begin
                    ok = (s >= 0) && (s < 32);
                    x  = (f7v << 25) | ((s & 31) << 20) | rs1f | (f3v << 12) | rdf | opc;
                end else begin
                    ok = alu_ok && b.alu != 2 && fits(s, 12);
                    x  = ((s & 'hFFF) << 20) | rs1f | (f3v << 12) | rdf | opc;
                end
            end
            2: begin
                ok = fits(s, 12) && (b.f3 inside {0, 1, 2, 4, 5});
                x  = ((s & 'hFFF) << 20) | rs1f | (b.f3 << 12) | rdf | opc;
            end
            3: begin
                ok = fits(s, 12) && b.f3 <= 2;
                x  = (((s >> 5) & 'h7F) << 25) | rs2f | rs1f | (b.f3 << 12) | ((s & 31) << 7) | opc;
            end
            4: begin
                ok = fits(s, 13) && ((s & 1) == 0) && b.f3 != 2 && b.f3 != 3;
                x  = (((s >> 12) & 1) << 31) | (((s >> 5) & 63) << 25) | rs2f | rs1f |
                     (b.f3 << 12) | (((s >> 1) & 15) << 8) | (((s >> 11) & 1) << 7) | opc;
            end
            5: begin
                ok = fits(s, 21) && ((s & 1) == 0);
                x  = (((s >> 20) & 1) << 31) | (((s >> 1) & 1023) << 21) |
                     (((s >> 11) & 1) << 20) | (((s >> 12) & 255) << 12) | rdf | opc;
            end
            6: begin
                ok = fits(s, 12);
                x  = ((s & 'hFFF) << 20) | rs1f | rdf | opc;
            end
            default: begin
                ok = (s & 'hFFF) == 0;
                x  = (s & 32'hFFFFF000) | rdf | opc;
            end
        endcase
        w = 32'(x);
    endfunction

    function automatic bundle_t mk(input int c, input int a, input int f, input int d,
                                   input int s1, input int s2, input int im);
        bundle_t b;
        b.cls = c; b.alu = a; b.f3 = f; b.rd = d; b.rs1 = s1; b.rs2 = s2; b.imm = im;
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        int v;
        b.cls = ($urandom_range(0, 19) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
        v = int'($urandom_range(0, 59));
        b.alu = (v < 54) ? int'($urandom_range(1, 10)) : ((v == 54) ? 0 : v - 44);
        b.f3  = int'($urandom_range(0, 7));
        b.rd  = int'($urandom_range(0, 31));
        b.rs1 = int'($urandom_range(0, 31));
        b.rs2 = int'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
            0, 1, 2: b.imm = (int'($urandom_range(0, 4095)) - 2048) & ~1;
            3:       b.imm = int'($urandom_range(0, 31));
            4:       b.imm = bnd[$urandom_range(0, 15)];
            default: b.imm = ($urandom_range(0, 1) == 0) ? int'($urandom() & 32'hFFFFF000)
                                                         : int'($urandom());
        endcase
        return b;
    endfunction

    function automatic bundle_t legal_bundle();
        bundle_t b;
        bit ok;
        logic [31:0] w;
        for (int i = 0; i < 1000; i++) begin
            b = rand_bundle();
            ref_enc(b, ok, w);
            if (ok) return b;
        end
        return mk(0, 1, 0, 1, 2, 3, 0);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic status(input string tag);
        check({tag, "_count"}, o_count, m_count);
        check({tag, "_full"}, o_full, m_full);
        check({tag, "_err"}, o_err, m_err);
        if (m_err) check({tag, "_err_idx"}, o_eidx, m_eidx);
        check({tag, "_ready"}, o_ready, m_open);
        check({tag, "_busy"}, o_busy, m_open);
        check({tag, "_we"}, o_we, 1'b0);
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_count = 0; m_open = 1'b1; m_full = 1'b0; m_err = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        step();
        finish = 1'b0;
        m_open = 1'b0;
    endtask

    // Offer one bundle; the loop is bounded so a stuck in_ready cannot hang the run
    task automatic send(input bundle_t b, input bit hold);
        bit ok, acc;
        logic [31:0] w;
        int addr;
        ref_enc(b, ok, w);
        cls = 4'(b.cls); alu_op = 4'(b.alu); f3 = 3'(b.f3);
        rd = 5'(b.rd); rs1 = 5'(b.rs1); rs2 = 5'(b.rs2); imm = 32'(b.imm);
        in_valid = 1'b1;
        acc = 1'b0;
        last_wait = 0;
        for (int i = 0; i < 6 && !acc; i++) begin
            if (o_ready) acc = 1'b1;
            last_wait++;
            step();
        end
        if (!hold || !m_open) in_valid = 1'b0;
        if (!m_open) begin
            check("no_accept", acc, 1'b0);
            return;
        end
        check("accept", acc, 1'b1);
        if (!acc) return;
        if (ok) begin
            addr = m_count;
            check("wr_we", o_we, 1'b1);
            check("wr_ready_low", o_ready, 1'b0);
            check("wr_addr", o_addr, addr);
            check("wr_data", o_data, w);
            last_word = o_data;
            exp_writes++;
            m_count++;
            if (addr == (1 << m_aw) - 1) begin
                m_open = 1'b0;
                m_full = 1'b1;
            end
        end else begin
            check("bad_no_we", o_we, 1'b0);
            m_err = 1'b1; m_eidx = m_count; m_open = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_open = 1'b0; m_full = 1'b0; m_err = 1'b0; m_eidx = 0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bundle_t b;
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        check("rst_addr", o_addr, 0);
        check("rst_data", o_data, 0);
        check("rst_eidx", o_eidx, 0);
        status("rst");
        rst_n = 1'b1;
        step();
        status("idle");

        // Reference program
        do_start();
        send(mk(0, 1, 0, 3, 1, 2, 0), 1'b0);   check("basic_add", last_word, 32'h002081B3);
        send(mk(1, 1, 0, 1, 0, 0, 5), 1'b0);   check("basic_addi", last_word, 32'h00500093);
        send(mk(0, 2, 0, 5, 6, 7, 0), 1'b0);   check("basic_sub", last_word, 32'h407302B3);
        send(mk(3, 0, 2, 0, 1, 2, 8), 1'b0);   check("basic_sw", last_word, 32'h0020A423);
        send(mk(4, 0, 0, 0, 1, 2, -4), 1'b0);  check("basic_beq", last_word, 32'hFE208EE3);
        send(mk(5, 0, 0, 1, 0, 0, 8), 1'b0);   check("basic_jal", last_word, 32'h008000EF);
        step();
        status("basic");

        // in_valid held high: one accept every second cycle
        for (int k = 0; k < 8; k++) begin
            send(legal_bundle(), 1'b1);
            if (k > 0) check("hs_gap", last_wait, 2);
        end
        in_valid = 1'b0;
        step();
        status("hs");

        // Illegal bundles
        do_start();
        send(mk(1, 1, 0, 1, 0, 0, 5), 1'b0);
        send(mk(0, 1, 0, 3, 1, 2, 0), 1'b0);
        send(mk(1, 1, 0, 2, 0, 0, 2048), 1'b0);
        step();
        status("ill_imm");
        send(legal_bundle(), 1'b0);
        do_start();
        send(mk(1, 2, 0, 1, 2, 0, 1), 1'b0);
        step();
        status("ill_subi");
        do_start();
        send(mk(4, 0, 0, 0, 1, 2, 3), 1'b0);
        step();
        status("ill_beq");

        // finish together with in_valid: the word wins, block keeps accepting
        do_start();
        finish = 1'b1;
        send(legal_bundle(), 1'b0);
        finish = 1'b0;
        step();
        status("fin_valid");
        do_finish();
        status("fin_idle");
        send(legal_bundle(), 1'b0);

        // start during WRITE: the write lands, then counters restart
        do_start();
        send(legal_bundle(), 1'b0);
        send(legal_bundle(), 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        m_count = 0; m_open = 1'b1;
        check("rs_addr", o_addr, 0);
        status("restart");

        // Randomized traffic
        do_start();
        for (int n = 0; n < 300; n++) begin
            send(rand_bundle(), 1'b0);
            step();
            if (n % 7 == 0) status("rand");
            if (m_open && $urandom_range(0, 30) == 0) begin
                do_finish();
                status("rand_fin");
            end
            if (!m_open) begin
                if (m_err) status("rand_err");
                do_start();
            end
        end

        // Small address space: four writes then full
        sel = 1'b1;
        m_aw = AW_SMALL;
        do_start();
        for (int k = 0; k < 5; k++) begin
            send(legal_bundle(), 1'b0);
            step();
        end
        status("full");
        check("full_addr", o_addr, 3);

        // Reset in the middle of a write
        sel = 1'b0;
        m_aw = AW_BIG;
        do_start();
        send(legal_bundle(), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_we", o_we, 1'b0);
        check("arst_addr", o_addr, 0);
        check("arst_data", o_data, 0);
        check("arst_eidx", o_eidx, 0);
        status("arst");
        step();
        rst_n = 1'b1;
        step();
        status("arst_idle");

        repeat (2) step();
        check("b2b_writes", mon_b2b, 0);
        check("write_total", mon_writes, exp_writes);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
